// File: rtl/aemb2_busarb.sv
`default_nettype none
// aemb2_busarb: round-robin arbiter sharing one Wishbone port between the dwb and xwb masters.
// Rev 1.0 -- define AEMB2_BUSARB_TIMEOUT_EN to enable the stalled-transfer watchdog.
module aemb2_busarb #(
  parameter int AEMB_DWB = 32,
  parameter int AEMB_XWB = 3,
  parameter logic [AEMB_DWB-AEMB_XWB-3:0] XWB_BASE = '1,
  parameter int TMO_W = 8
) (
  input  logic                    gclk,
  input  logic                    grst,
  // data bus master
  input  logic [AEMB_DWB-1:2]     dwb_adr_i,
  input  logic [31:0]             dwb_dat_i,
  input  logic [3:0]              dwb_sel_i,
  input  logic                    dwb_stb_i,
  input  logic                    dwb_cyc_i,
  input  logic                    dwb_wre_i,
  input  logic                    dwb_tag_i,
  output logic                    dwb_ack_o,
  output logic [31:0]             dwb_dat_o,
  // extension bus master
  input  logic [AEMB_XWB+1:2]     xwb_adr_i,
  input  logic [31:0]             xwb_dat_i,
  input  logic [3:0]              xwb_sel_i,
  input  logic                    xwb_stb_i,
  input  logic                    xwb_cyc_i,
  input  logic                    xwb_wre_i,
  input  logic                    xwb_tag_i,
  output logic                    xwb_ack_o,
  output logic [31:0]             xwb_dat_o,
  // shared bus
  output logic [AEMB_DWB-1:2]     mwb_adr_o,
  output logic [31:0]             mwb_dat_o,
  output logic [3:0]              mwb_sel_o,
  output logic                    mwb_stb_o,
  output logic                    mwb_cyc_o,
  output logic                    mwb_wre_o,
  output logic                    mwb_tag_o,
  input  logic                    mwb_ack_i,
  input  logic [31:0]             mwb_dat_i,
  output logic [1:0]              mwb_gnt_o,
  output logic                    tmo_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_X = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   lst_q, lst_d;   // 1: xwb was the most recent owner
  logic   own_d, own_x;
  logic   own_stb;
  logic   tmo;

  always_comb begin
    state_d = state_q;
    lst_d   = lst_q;
    unique case (state_q)
      IDLE: begin
        if (dwb_cyc_i && xwb_cyc_i) state_d = lst_q ? GNT_D : GNT_X;
        else if (dwb_cyc_i)         state_d = GNT_D;
        else if (xwb_cyc_i)         state_d = GNT_X;
      end
      GNT_D: begin
        // hand straight to a waiting master so no idle cycle is inserted
        if (!dwb_cyc_i) state_d = xwb_cyc_i ? GNT_X : IDLE;
      end
      GNT_X: begin
        if (!xwb_cyc_i) state_d = dwb_cyc_i ? GNT_D : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != IDLE) lst_d = (state_d == GNT_X);
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state_q <= IDLE;
      lst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      lst_q   <= lst_d;
    end
  end

  assign own_d     = (state_q == GNT_D);
  assign own_x     = (state_q == GNT_X);
  assign own_stb   = (own_d & dwb_stb_i) | (own_x & xwb_stb_i);
  assign mwb_gnt_o = {own_x, own_d};

`ifdef AEMB2_BUSARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tmo   = own_stb & ~mwb_ack_i & (cnt_q == {TMO_W{1'b1}});
    cnt_d = cnt_q;
    if ((state_d != state_q) || mwb_ack_i || tmo) cnt_d = '0;
    else if (own_stb)                              cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  assign tmo_o = tmo;

  always_comb begin
    mwb_adr_o = '0;
    mwb_dat_o = '0;
    mwb_sel_o = '0;
    mwb_stb_o = 1'b0;
    mwb_cyc_o = 1'b0;
    mwb_wre_o = 1'b0;
    mwb_tag_o = 1'b0;
    unique case (state_q)
      GNT_D: begin
        mwb_adr_o = dwb_adr_i;
        mwb_dat_o = dwb_dat_i;
        mwb_sel_o = dwb_sel_i;
        mwb_stb_o = dwb_stb_i;
        mwb_cyc_o = dwb_cyc_i;
        mwb_wre_o = dwb_wre_i;
        mwb_tag_o = dwb_tag_i;
      end
      GNT_X: begin
        mwb_adr_o = {XWB_BASE, xwb_adr_i};
        mwb_dat_o = xwb_dat_i;
        mwb_sel_o = xwb_sel_i;
        mwb_stb_o = xwb_stb_i;
        mwb_cyc_o = xwb_cyc_i;
        mwb_wre_o = xwb_wre_i;
        mwb_tag_o = xwb_tag_i;
      end
      default: ;
    endcase
    // watchdog abort releases the slave for the cycle it fakes the ack
    if (tmo) begin
      mwb_stb_o = 1'b0;
      mwb_cyc_o = 1'b0;
    end
  end

  assign dwb_ack_o = own_d & (mwb_ack_i | tmo);
  assign xwb_ack_o = own_x & (mwb_ack_i | tmo);
  assign dwb_dat_o = (own_d & tmo) ? 32'h0 : mwb_dat_i;
  assign xwb_dat_o = (own_x & tmo) ? 32'h0 : mwb_dat_i;

endmodule
`default_nettype wire
